fpadd_arbiter: RTL

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/fpadd_arbiter.sv
// Two-requester round-robin front end for a shared pipelined FP32 adder.
// A {valid, id} tag pipeline matched to the adder latency steers each sum back to its requester.
module fpadd_arbiter #(
    parameter int unsigned ADD_LATENCY = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             req1_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             resp0_valid,
    output logic [31:0]      resp0_data,
    output logic             resp1_valid,
    output logic [31:0]      resp1_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic                   last_id;
    logic                   grant_id;
    logic                   accept;
    logic [ADD_LATENCY-1:0] tag_valid;
    logic [ADD_LATENCY-1:0] tag_id;
    logic                   out_valid;
    logic                   out_id;

    // last_id resets to 1 so requester 0 wins the first contention
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_id   = 1'b0;
        add_a      = '0;
        add_b      = '0;
        if (reset) begin
            if (req0_valid && req1_valid) begin
                grant_id = ~last_id;
            end else begin
                grant_id = req1_valid;
            end
            req0_ready = req0_valid && !grant_id;
            req1_ready = req1_valid && grant_id;
        end
        if (req0_ready) begin
            add_a = req0_a;
            add_b = req0_b;
        end else if (req1_ready) begin
            add_a = req1_a;
            add_b = req1_b;
        end
    end

    assign accept = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_id   <= 1'b1;
            tag_valid <= '0;
            tag_id    <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                last_id <= grant_id;
            end
            tag_valid[0] <= accept;
            tag_id[0]    <= grant_id;
            for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            if (out_valid) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign out_valid = tag_valid[ADD_LATENCY-1];
    assign out_id    = tag_id[ADD_LATENCY-1];
    assign busy      = |tag_valid;

    always_comb begin
        resp0_valid = out_valid && !out_id;
        resp1_valid = out_valid && out_id;
        resp0_data  = resp0_valid ? add_result : '0;
        resp1_data  = resp1_valid ? add_result : '0;
    end

endmodule
